vga_timing_gen: RTL

//  Parametrised VGA raster timing generator; successor to the fixed 640x480 sync generator.

---
 rtl/vga_timing_gen.sv | 139 +++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parameterised VGA raster timing generator.
// Counts pixels/lines on the pixel clock-enable and decodes sync, display
// area and line/frame strobes, each registered one ce behind the counters.
// Optional feature macro: VGA_FRAME_COUNT_EN adds an 8-bit frame_count
// output that increments on every registered frame_start.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CNT_W    = 10
) (
  input  logic             VGA_clk,
  input  logic             reset,
  input  logic             pix_ce,
  output logic             VGA_Hsync,
  output logic             VGA_Vsync,
  output logic             DisplayArea,
  output logic             blank_n,
  output logic [CNT_W-1:0] xCounter,
  output logic [CNT_W-1:0] yCounter,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [7:0]       frame_count
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Bad timing parameters are rejected at elaboration.
  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      CNT_W < 1 || CNT_W > 30 ||
      (H_TOTAL - 1) >= (1 << CNT_W) || (V_TOTAL - 1) >= (1 << CNT_W)) begin : g_param_err
    $error("vga_timing_gen: illegal timing parameters or CNT_W too small");
  end

  // Decode thresholds pre-sized to the counter width so every compare is
  // same-width and exact.
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             de_q, de_d;
  logic             ls_q, ls_d;
  logic             fs_q, fs_d;

  // Next state: counters advance and decodes sample the pre-update position
  // only on pix_ce; strobes drop whenever ce is low.
  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    hs_d = hs_q;
    vs_d = vs_q;
    de_d = de_q;
    ls_d = 1'b0;
    fs_d = 1'b0;
    if (pix_ce) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
      de_d = (x_q < H_ACT) && (y_q < V_ACT);
      hs_d = ((x_q >= HS_BEG) && (x_q < HS_END)) ? HS_POL : ~HS_POL;
      vs_d = ((y_q >= VS_BEG) && (y_q < VS_END)) ? VS_POL : ~VS_POL;
      ls_d = (x_q == '0);
      fs_d = (x_q == '0) && (y_q == '0);
    end
  end

  // Raster state register; reset parks syncs at their inactive level.
  always_ff @(posedge VGA_clk or posedge reset) begin
    if (reset) begin
      x_q  <= '0;
      y_q  <= '0;
      hs_q <= ~HS_POL;
      vs_q <= ~VS_POL;
      de_q <= 1'b0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      de_q <= de_d;
      ls_q <= ls_d;
      fs_q <= fs_d;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] fc_q, fc_d;

  // Frame counter bumps in the same clock that frame_start is registered.
  always_comb begin
    fc_d = fc_q;
    if (fs_d) fc_d = fc_q + 8'd1;
  end

  // Frame counter register, wraps naturally at 256.
  always_ff @(posedge VGA_clk or posedge reset) begin
    if (reset) fc_q <= 8'd0;
    else       fc_q <= fc_d;
  end

  assign frame_count = fc_q;
`endif

  assign xCounter    = x_q;
  assign yCounter    = y_q;
  assign VGA_Hsync   = hs_q;
  assign VGA_Vsync   = vs_q;
  assign DisplayArea = de_q;
  assign blank_n     = de_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule
